eep_access_arbiter: RTL and testbench

//  Shares the single EEPROM (XSET/P/I/D words) between two requesters:
//  - the PID loop sequencer (reads only);
//  - the UART command interpreter (reads, and writes that need the charge pump).

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/eep_chrg_timer.sv | 38 +++
 rtl/eep_access_arbiter.sv | 154 +++++++++++++++
 tb/tb_eep_access_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions: EEPROM word map, arbiter state encoding and
// the default charge-pump write duration.
package ctrl_pkg;

    localparam logic [1:0] XSET_ADR = 2'd0;
    localparam logic [1:0] P_ADR    = 2'd1;
    localparam logic [1:0] I_ADR    = 2'd2;
    localparam logic [1:0] D_ADR    = 2'd3;

    localparam int              CNT_W           = 22;
    localparam logic [CNT_W-1:0] CHRG_CYCLES_DEF = 22'h249F00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2,
        ST_WR   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/eep_chrg_timer.sv
// Charge-pump write timer: cleared on entry to a write, counts up and
// flags the last write cycle. Holds at terminal count rather than wrapping.
module eep_chrg_timer
    import ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] CHRG_CYCLES = CHRG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [CNT_W-1:0] TC = CHRG_CYCLES - 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eep_access_arbiter.sv
// Shares the EEPROM between the PID loop sequencer (read-only, priority) and
// the UART command interpreter (read/write), with starvation relief for cmd.
module eep_access_arbiter
    import ctrl_pkg::*;
#(
    parameter int               ADDR_W      = 2,
    parameter int               DATA_W      = 14,
    parameter logic [CNT_W-1:0] CHRG_CYCLES = CHRG_CYCLES_DEF,
    parameter int               STARVE_MAX  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lp_req,
    input  logic [ADDR_W-1:0] lp_addr,
    output logic              lp_gnt,
    output logic              lp_vld,
    output logic [DATA_W-1:0] lp_rdata,
    input  logic              cm_req,
    input  logic              cm_wr,
    input  logic [ADDR_W-1:0] cm_addr,
    input  logic [DATA_W-1:0] cm_wdata,
    output logic              cm_gnt,
    output logic              cm_done,
    output logic [DATA_W-1:0] cm_rdata,
    output logic [ADDR_W-1:0] eep_addr,
    output logic [DATA_W-1:0] eep_wdata,
    input  logic [DATA_W-1:0] eep_rdata,
    output logic              eep_cs_n,
    output logic              eep_r_w_n,
    output logic              chrg_pmp_en,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    logic              owner_cm_q, owner_cm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] lp_rdata_q, lp_rdata_d;
    logic [DATA_W-1:0] cm_rdata_q, cm_rdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              starve_hit;
    logic              tmr_clr, tmr_inc, tmr_expired;

    assign starve_hit = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        state_d    = state_q;
        owner_cm_d = owner_cm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lp_rdata_d = lp_rdata_q;
        cm_rdata_d = cm_rdata_q;
        starve_d   = starve_q;
        lp_gnt     = 1'b0;
        cm_gnt     = 1'b0;
        lp_vld     = 1'b0;
        cm_done    = 1'b0;
        tmr_clr    = 1'b0;
        tmr_inc    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lp_req && !(cm_req && starve_hit)) begin
                    lp_gnt     = 1'b1;
                    owner_cm_d = 1'b0;
                    addr_d     = lp_addr;
                    state_d    = ST_RD;
                end else if (cm_req) begin
                    cm_gnt     = 1'b1;
                    owner_cm_d = 1'b1;
                    addr_d     = cm_addr;
                    if (cm_wr) begin
                        wdata_d = cm_wdata;
                        tmr_clr = 1'b1;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (owner_cm_q) begin
                    cm_rdata_d = eep_rdata;
                end else begin
                    lp_rdata_d = eep_rdata;
                end
                state_d = ST_RSP;
            end
            ST_RSP: begin
                lp_vld  = !owner_cm_q;
                cm_done = owner_cm_q;
                state_d = ST_IDLE;
            end
            ST_WR: begin
                tmr_inc = 1'b1;
                if (tmr_expired) begin
                    cm_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Starvation count only matters while a cmd request is actually waiting.
        if (cm_gnt || !cm_req) begin
            starve_d = '0;
        end else if (lp_gnt && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_cm_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lp_rdata_q <= '0;
            cm_rdata_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_cm_q <= owner_cm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lp_rdata_q <= lp_rdata_d;
            cm_rdata_q <= cm_rdata_d;
            starve_q   <= starve_d;
        end
    end

    eep_chrg_timer #(
        .CHRG_CYCLES (CHRG_CYCLES)
    ) u_chrg_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // EEPROM strobes decode straight from the state flop so reset releases them at once.
    assign eep_cs_n    = !((state_q == ST_RD) || (state_q == ST_WR));
    assign eep_r_w_n   = (state_q != ST_WR);
    assign chrg_pmp_en = (state_q == ST_WR);
    assign busy        = (state_q != ST_IDLE);
    assign eep_addr    = addr_q;
    assign eep_wdata   = wdata_q;
    assign lp_rdata    = lp_rdata_q;
    assign cm_rdata    = cm_rdata_q;

endmodule

// File: tb/tb_eep_access_arbiter.sv
// Self-checking bench for eep_access_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-timeline reference model.
module tb_eep_access_arbiter;
    import ctrl_pkg::*;

    localparam int CHRG   = 16;
    localparam int SMAX   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lp_req = 1'b0;
    logic [1:0]  lp_addr = '0;
    logic        lp_gnt, lp_vld;
    logic [13:0] lp_rdata;
    logic        cm_req = 1'b0;
    logic        cm_wr = 1'b0;
    logic [1:0]  cm_addr = '0;
    logic [13:0] cm_wdata = '0;
    logic        cm_gnt, cm_done;
    logic [13:0] cm_rdata;
    logic [1:0]  eep_addr;
    logic [13:0] eep_wdata;
    logic [13:0] eep_rdata;
    logic        eep_cs_n, eep_r_w_n, chrg_pmp_en, busy;

    always #5 clk = ~clk;

    eep_access_arbiter #(
        .ADDR_W      (2),
        .DATA_W      (14),
        .CHRG_CYCLES (22'd16),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lp_req      (lp_req),
        .lp_addr     (lp_addr),
        .lp_gnt      (lp_gnt),
        .lp_vld      (lp_vld),
        .lp_rdata    (lp_rdata),
        .cm_req      (cm_req),
        .cm_wr       (cm_wr),
        .cm_addr     (cm_addr),
        .cm_wdata    (cm_wdata),
        .cm_gnt      (cm_gnt),
        .cm_done     (cm_done),
        .cm_rdata    (cm_rdata),
        .eep_addr    (eep_addr),
        .eep_wdata   (eep_wdata),
        .eep_rdata   (eep_rdata),
        .eep_cs_n    (eep_cs_n),
        .eep_r_w_n   (eep_r_w_n),
        .chrg_pmp_en (chrg_pmp_en),
        .busy        (busy)
    );

    // EEPROM model: async read, write commits on the final charge-pump cycle.
    logic [13:0] eep_mem [4];
    assign eep_rdata = (!eep_cs_n && eep_r_w_n) ? eep_mem[eep_addr] : 14'h0000;

    initial begin
        eep_mem[XSET_ADR] = 14'h0A5A;
        eep_mem[P_ADR]    = 14'h0123;
        eep_mem[I_ADR]    = 14'h0456;
        eep_mem[D_ADR]    = 14'h0FFF;
    end

    always @(posedge clk) begin
        if (rst_n && !eep_cs_n && !eep_r_w_n && cm_done) begin
            eep_mem[eep_addr] = eep_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked by cycles since grant.
    logic [13:0] m_mem [4];
    bit          m_active = 0;
    int          m_age = 0;
    bit          m_lp = 0;
    bit          m_wr = 0;
    logic [1:0]  m_addr = '0;
    logic [13:0] m_wdata = '0;
    logic [13:0] m_lp_rdata = '0;
    logic [13:0] m_cm_rdata = '0;
    int          m_starve = 0;
    int          cyc = 0;
    bit          last_lg = 0, last_cg = 0, obs_pmp = 0, obs_cd = 0;

    initial begin
        m_mem[0] = 14'h0A5A;
        m_mem[1] = 14'h0123;
        m_mem[2] = 14'h0456;
        m_mem[3] = 14'h0FFF;
    end

    task automatic step();
        bit e_lg, e_cg, e_lv, e_cd, e_csn, e_rwn, e_pmp, e_busy;
        @(negedge clk);
        e_lg = 0; e_cg = 0; e_lv = 0; e_cd = 0;
        e_csn = 1; e_rwn = 1; e_pmp = 0; e_busy = 0;
        if (!m_active) begin
            if (lp_req && !(cm_req && m_starve >= SMAX)) e_lg = 1;
            else if (cm_req) e_cg = 1;
        end else begin
            e_busy = 1;
            if (m_wr) begin
                e_csn = 0; e_rwn = 0; e_pmp = 1;
                if (m_age == CHRG) e_cd = 1;
            end else if (m_age == 1) begin
                e_csn = 0;
            end else if (m_lp) begin
                e_lv = 1;
            end else begin
                e_cd = 1;
            end
        end
        chk("lp_gnt", lp_gnt, e_lg);
        chk("cm_gnt", cm_gnt, e_cg);
        chk("lp_vld", lp_vld, e_lv);
        chk("cm_done", cm_done, e_cd);
        chk("eep_cs_n", eep_cs_n, e_csn);
        chk("eep_r_w_n", eep_r_w_n, e_rwn);
        chk("chrg_pmp_en", chrg_pmp_en, e_pmp);
        chk("busy", busy, e_busy);
        chk("lp_rdata", lp_rdata, m_lp_rdata);
        chk("cm_rdata", cm_rdata, m_cm_rdata);
        if (m_active) chk("eep_addr", eep_addr, m_addr);
        if (m_active && m_wr) chk("eep_wdata", eep_wdata, m_wdata);

        if (e_cg || !cm_req) m_starve = 0;
        else if (e_lg) m_starve++;

        if (e_lg) begin
            m_active = 1; m_age = 1; m_lp = 1; m_wr = 0; m_addr = lp_addr;
        end else if (e_cg) begin
            m_active = 1; m_age = 1; m_lp = 0; m_wr = cm_wr; m_addr = cm_addr;
            if (cm_wr) m_wdata = cm_wdata;
        end else if (m_active) begin
            if (!m_wr && m_age == 1) begin
                if (m_lp) m_lp_rdata = m_mem[m_addr];
                else      m_cm_rdata = m_mem[m_addr];
            end
            if (m_wr && m_age == CHRG) m_mem[m_addr] = m_wdata;
            if (m_age == (m_wr ? CHRG : 2)) m_active = 0;
            else m_age++;
        end
        last_lg = lp_gnt; last_cg = cm_gnt; obs_pmp = chrg_pmp_en; obs_cd = cm_done;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out(input int n);
        lp_req = 0; cm_req = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pmp_cnt, done_at, lg_at, cd_at, ng;
        bit order [6];
        bit exp_order [6];
        exp_order = '{0, 0, 1, 0, 0, 1};

        #2;
        chk("rst_cs_n", eep_cs_n, 1);
        chk("rst_r_w_n", eep_r_w_n, 1);
        chk("rst_pmp", chrg_pmp_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", lp_vld, 0);
        chk("rst_done", cm_done, 0);
        chk("rst_addr", eep_addr, 0);
        chk("rst_wdata", eep_wdata, 0);
        chk("rst_lp_rdata", lp_rdata, 0);
        chk("rst_cm_rdata", cm_rdata, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: loop read of word 1
        lp_req = 1; lp_addr = P_ADR;
        step();
        lp_req = 0;
        step(); step();
        chk("t1_lp_rdata", lp_rdata, 14'h0123);
        idle_out(2);

        // 2: cmd write 0x1ABC to word 2, then loop readback
        cm_req = 1; cm_wr = 1; cm_addr = I_ADR; cm_wdata = 14'h1ABC;
        step();
        cm_req = 0;
        pmp_cnt = 0; done_at = 0;
        for (int i = 0; i < CHRG + 4; i++) begin
            step();
            if (obs_pmp) pmp_cnt++;
            if (obs_cd) done_at = pmp_cnt;
        end
        chk("t2_pmp_cycles", pmp_cnt, CHRG);
        chk("t2_done_cycle", done_at, CHRG);
        lp_req = 1; lp_addr = I_ADR;
        step();
        lp_req = 0;
        step(); step();
        chk("t2_readback", lp_rdata, 14'h1ABC);
        idle_out(2);

        // 3: continuous contention
        lp_req = 1; lp_addr = XSET_ADR; cm_req = 1; cm_wr = 0; cm_addr = D_ADR;
        ng = 0;
        for (int i = 0; i < 40 && ng < 6; i++) begin
            step();
            if (last_lg && last_cg) chk("t3_double_gnt", 1, 0);
            if (last_lg || last_cg) begin
                order[ng] = last_cg;
                ng++;
            end
        end
        chk("t3_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), order[i], exp_order[i]);
        idle_out(3);

        // 4: loop request arriving during a write
        cm_req = 1; cm_wr = 1; cm_addr = D_ADR; cm_wdata = 14'h0FFF;
        step();
        cm_req = 0; lp_req = 1; lp_addr = P_ADR;
        lg_at = -1; cd_at = -1;
        for (int i = 0; i < CHRG + 6 && lg_at < 0; i++) begin
            step();
            if (obs_cd) cd_at = cyc;
            if (last_lg) lg_at = cyc;
        end
        lp_req = 0;
        chk("t4_gnt_after_done", lg_at, cd_at + 1);
        step(); step();
        idle_out(2);

        // 5: async reset in write cycle 5
        cm_req = 1; cm_wr = 1; cm_addr = P_ADR; cm_wdata = 14'h2222;
        step();
        cm_req = 0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        chk("t5_pmp", chrg_pmp_en, 0);
        chk("t5_cs_n", eep_cs_n, 1);
        chk("t5_done", cm_done, 0);
        chk("t5_busy", busy, 0);
        m_active = 0; m_starve = 0; m_lp_rdata = '0; m_cm_rdata = '0;
        repeat (3) @(posedge clk);
        #1 chk("t5_done_in_rst", cm_done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy_after", busy, 0);
        lp_req = 1; lp_addr = P_ADR;
        step();
        lp_req = 0;
        step(); step();
        chk("t5_no_commit", lp_rdata, 14'h0123);
        idle_out(2);

        // 6: cmd read word 3 then loop read word 0 back-to-back
        cm_req = 1; cm_wr = 0; cm_addr = D_ADR;
        step();
        cm_req = 0; lp_req = 1; lp_addr = XSET_ADR;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_lg) lp_req = 0;
        end
        chk("t6_cm_rdata", cm_rdata, 14'h0FFF);
        chk("t6_lp_rdata", lp_rdata, 14'h0A5A);
        idle_out(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (last_lg) lp_req = 0;
            else if (!lp_req && $urandom_range(3) == 0) begin
                lp_req = 1; lp_addr = 2'($urandom_range(3));
            end else if (lp_req && $urandom_range(15) == 0) lp_req = 0;
            if (last_cg) cm_req = 0;
            else if (!cm_req && $urandom_range(3) == 0) begin
                cm_req = 1; cm_addr = 2'($urandom_range(3));
                cm_wr = ($urandom_range(3) == 0);
                cm_wdata = 14'($urandom);
            end else if (cm_req && $urandom_range(15) == 0) cm_req = 0;
            step();
        end
        idle_out(CHRG + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
